// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: fetches over a req/ack handshake,
// issues one-shot stage strobes and advances the PC on retire.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    output logic [31:0] instr_out,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic [31:0] pc,
    output logic [31:0] retire_cnt,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0] TMO_LAST  = 8'(FETCH_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic        got_instr;
    logic [6:0]  opcode;
    logic        legal_op;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic [31:0] next_pc;
    logic        retire_go;

    assign opcode = instr_out[6:0];
    assign imm_b  = {{19{instr_out[31]}}, instr_out[31], instr_out[7],
                     instr_out[30:25], instr_out[11:8], 1'b0};
    assign imm_j  = {{11{instr_out[31]}}, instr_out[31], instr_out[19:12],
                     instr_out[20], instr_out[30:21], 1'b0};

    always_comb begin
        next_pc = pc + 32'd4;
        if (opcode == OP_BRANCH && br_taken)
            next_pc = pc + imm_b;
        else if (opcode == OP_JAL)
            next_pc = pc + imm_j;
    end

    always_comb begin
        legal_op = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
            OP_LUI, OP_OP, OP_IMM: legal_op = 1'b1;
            default:               legal_op = 1'b0;
        endcase
    end

    // The last stage of each instruction class is where the PC moves on.
    assign retire_go = !stall &&
                       ((state == S_EXEC && opcode == OP_BRANCH) ||
                        (state == S_MEM  && opcode == OP_STORE)  ||
                        (state == S_WB));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            instr_out  <= 32'd0;
            retire_cnt <= 32'd0;
            tmo_cnt    <= 8'd0;
            got_instr  <= 1'b0;
            imem_req   <= 1'b0;
        end else if (retire_go) begin
            if (|next_pc[1:0]) begin
                state <= S_FAULT;
            end else begin
                pc         <= next_pc;
                retire_cnt <= retire_cnt + 32'd1;
                state      <= S_FETCH;
                imem_req   <= 1'b1;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    imem_req <= 1'b1;
                    if (imem_ack) begin
                        instr_out <= imem_rdata;
                        tmo_cnt   <= 8'd0;
                    end
                    // A word acked while stalled is parked until the stall lifts.
                    if (stall) begin
                        if (imem_ack)
                            got_instr <= 1'b1;
                    end else if (imem_ack || got_instr) begin
                        state     <= S_DECODE;
                        imem_req  <= 1'b0;
                        got_instr <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= S_FAULT;
                        imem_req <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DECODE: if (!stall) begin
                    if (opcode == OP_SYSTEM) begin
                        state      <= S_HALT;
                        retire_cnt <= retire_cnt + 32'd1;
                    end else if (legal_op) begin
                        state <= S_EXEC;
                    end else begin
                        state <= S_FAULT;
                    end
                end
                S_EXEC: if (!stall) begin
                    if (opcode == OP_LOAD || opcode == OP_STORE)
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_MEM:   if (!stall) state <= S_WB;
                default: state <= state;
            endcase
        end
    end

    // Strobes fire in the cycle the stage actually completes, i.e. once per visit.
    assign decode_en = (state == S_DECODE) && !stall;
    assign exec_en   = (state == S_EXEC)   && !stall;
    assign mem_en    = (state == S_MEM)    && !stall;
    assign wb_en     = (state == S_WB)     && !stall;
    assign halted    = (state == S_HALT);
    assign fault     = (state == S_FAULT);
    assign imem_addr = pc;

endmodule
